// File: rtl/uart_reg_master.sv
// uart_reg_master
//   Byte-serial command parser that drives the UART register-file access port.
//   Write command: 0x57, addr, d0..d3 (LSB first) -> one reg_wr_o pulse, reply 0x4B.
//   Read  command: 0x52, addr -> one reg_rd_o pulse, reply rdata as 4 bytes LSB first.
//   Unknown opcode -> err_o pulse, reply 0x45.
//   A command stalled mid-way for TIMEOUT_CYC cycles is dropped with an err_o pulse.
//
// Ports
//   sclk, rstn                      clock, asynchronous active-low reset
//   cmd_data_i/valid_i/ready_o      command byte stream (consumed on valid & ready)
//   rsp_data_o/valid_o/ready_i      response byte stream (sent on valid & ready)
//   reg_addr_o, reg_wdata_o         register address / write data
//   reg_wr_o, reg_rd_o              single-cycle write / read strobes
//   reg_rdata_i                     combinational read data, valid while reg_rd_o
//   busy_o                          command or response in progress
//   err_o                           one-cycle pulse on bad opcode or timeout
module uart_reg_master #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = 16
) (
  input  logic        sclk,
  input  logic        rstn,
  input  logic [7:0]  cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  input  logic [31:0] reg_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    RSP   = 3'd5
  } state_t;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  // Abort fires on the cycle the counter would reach TIMEOUT_CYC.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic [2:0]      rsp_cnt_q, rsp_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            acc;

  assign cmd_ready_o = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign acc         = cmd_valid_i && cmd_ready_o;

  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = shift_q[7:0];
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wr_o    = (state_q == WRITE);
  assign reg_rd_o    = (state_q == READ);
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rsp_cnt_d = rsp_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (acc) begin
          if (cmd_data_i == OP_WR || cmd_data_i == OP_RD) begin
            is_wr_d = (cmd_data_i == OP_WR);
            state_d = ADDR;
          end else begin
            shift_d   = {24'h0, RSP_ERR};
            rsp_cnt_d = 3'd1;
            err_d     = 1'b1;
            state_d   = RSP;
          end
        end
      end
      ADDR: begin
        if (acc) begin
          addr_d = cmd_data_i;
          if (is_wr_q) begin
            cnt_d   = 2'd0;
            state_d = DATA;
          end else begin
            state_d = READ;
          end
        end
      end
      DATA: begin
        if (acc) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = cmd_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        shift_d   = {24'h0, RSP_ACK};
        rsp_cnt_d = 3'd1;
        state_d   = RSP;
      end
      READ: begin
        // rdata is combinational from the regfile and valid only in this cycle
        shift_d   = reg_rdata_i;
        rsp_cnt_d = 3'd4;
        state_d   = RSP;
      end
      RSP: begin
        if (rsp_ready_i) begin
          shift_d   = {8'h0, shift_q[31:8]};
          rsp_cnt_d = rsp_cnt_q - 3'd1;
          if (rsp_cnt_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte timeout while waiting for the rest of a command
    if (state_q == ADDR || state_q == DATA) begin
      if (acc) begin
        to_cnt_d = '0;
      end else if (TIMEOUT_CYC > 0) begin
        if (to_cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      rsp_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rsp_cnt_q <= rsp_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master
//   Drives byte commands into uart_reg_master, backs it with a simple regfile,
//   and compares strobes and response bytes against a transaction-level model
//   (expected strobe queue plus a model copy of register contents).
module tb_uart_reg_master;

  logic        sclk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  cmd_data_i = 8'h00;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [31:0] reg_rdata_i;
  logic        busy_o;
  logic        err_o;

  uart_reg_master #(.TIMEOUT_CYC(1000), .TO_W(16)) dut (
    .sclk(sclk), .rstn(rstn),
    .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Power-on register contents; 0x20 holds the value the directed read expects.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h20) return 32'h0000_0102;
    return {a ^ 8'hA5, ~a, a + 8'h33, a};
  endfunction

  // Bench regfile driven by the DUT strobes
  logic [31:0] rf [256];
  bit          rf_vld [256];
  always @(posedge sclk) begin
    if (reg_wr_o) begin
      rf[reg_addr_o]     <= reg_wdata_o;
      rf_vld[reg_addr_o] <= 1'b1;
    end
  end
  always_comb reg_rdata_i = rf_vld[reg_addr_o] ? rf[reg_addr_o] : init_val(reg_addr_o);

  // Model of register contents, updated from the commands the bench sends
  logic [31:0] mdl [256];
  bit          mdl_vld [256];
  function automatic logic [31:0] mdl_rd(input logic [7:0] a);
    return mdl_vld[a] ? mdl[a] : init_val(a);
  endfunction

  typedef struct {bit wr; logic [7:0] a; logic [31:0] d;} strobe_t;
  strobe_t sq[$];
  strobe_t s_mon;
  int n_wr = 0, n_rd = 0, n_errp = 0;

  always @(negedge sclk) begin
    if (reg_wr_o || reg_rd_o) begin
      if (reg_wr_o && reg_rd_o) check("strobe_excl", 32'd1, 32'd0);
      if (reg_wr_o) n_wr++; else n_rd++;
      if (sq.size() == 0) begin
        check("spurious_strobe", 32'd1, 32'd0);
      end else begin
        s_mon = sq.pop_front();
        check("strobe_kind", {31'd0, reg_wr_o}, {31'd0, s_mon.wr});
        check("strobe_addr", {24'd0, reg_addr_o}, {24'd0, s_mon.a});
        if (s_mon.wr) check("strobe_wdata", reg_wdata_o, s_mon.d);
      end
    end
    if (err_o) n_errp++;
  end

  task automatic send_byte(input logic [7:0] b);
    int  k;
    bit  r;
    cmd_data_i  = b;
    cmd_valid_i = 1'b1;
    for (k = 0; k < 200; k++) begin
      r = cmd_ready_o;
      @(posedge sclk);
      if (r) break;
      @(negedge sclk);
    end
    #1;
    cmd_valid_i = 1'b0;
    if (k == 200) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_rsp(input int n, input logic [31:0] exp, input bit force_rdy);
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge sclk);
        rsp_ready_i = force_rdy || ($urandom_range(0, 3) != 0);
        if (rsp_valid_o && rsp_ready_i) begin
          check("rsp_byte", {24'd0, rsp_data_o}, {24'd0, exp[8*i +: 8]});
          got = 1'b1;
          @(posedge sclk);
          break;
        end
      end
      if (!got) check("rsp_timeout", 32'd0, 32'd1);
    end
    @(negedge sclk);
    rsp_ready_i = 1'b0;
    check("busy_after_rsp", {31'd0, busy_o}, 32'd0);
    check("rsp_valid_after", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'h57);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    sq.push_back('{wr: 1'b1, a: a, d: d});
    send_byte(d[31:24]);
    check("wr_latency", {31'd0, reg_wr_o}, 32'd1);
    mdl[a]     = d;
    mdl_vld[a] = 1'b1;
    @(posedge sclk); #1;
    check("wr_rsp_latency", {31'd0, rsp_valid_o}, 32'd1);
    get_rsp(1, 32'h4B, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] a);
    logic [31:0] e;
    send_byte(8'h52);
    sq.push_back('{wr: 1'b0, a: a, d: 32'd0});
    send_byte(a);
    check("rd_latency", {31'd0, reg_rd_o}, 32'd1);
    e = mdl_rd(a);
    @(posedge sclk); #1;
    check("rd_rsp_latency", {31'd0, rsp_valid_o}, 32'd1);
    get_rsp(4, e, 1'b0);
  endtask

  task automatic do_bad(input logic [7:0] b);
    int e0, w0, r0;
    e0 = n_errp; w0 = n_wr; r0 = n_rd;
    send_byte(b);
    check("bad_err", {31'd0, err_o}, 32'd1);
    check("bad_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    get_rsp(1, 32'h45, 1'b0);
    check("bad_err_once", n_errp - e0, 32'd1);
    check("bad_no_strobe", (n_wr - w0) + (n_rd - r0), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k, e0, w0, r0, wr_total;
    logic [7:0]  b, a;
    logic [31:0] d;

    // Reset state
    #12;
    check("rst_addr", {24'd0, reg_addr_o}, 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_strobes", {30'd0, reg_wr_o, reg_rd_o}, 32'd0);
    check("rst_rsp", {23'd0, rsp_valid_o, rsp_data_o}, 32'd0);
    check("rst_busy_err", {30'd0, busy_o, err_o}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge sclk);
    rstn = 1'b1;
    @(negedge sclk);

    // Directed write and read
    do_write(8'h02, 32'h0000_01B2);
    do_read(8'h20);

    // Bad opcode then a normal read
    do_bad(8'h41);
    do_read(8'h00);

    // Timeout mid-command
    e0 = n_errp; w0 = n_wr; r0 = n_rd;
    send_byte(8'h57);
    send_byte(8'h01);
    for (k = 0; k < 1100; k++) begin
      @(posedge sclk); #1;
      if (err_o) break;
    end
    check("timeout_cycles", k + 1, 32'd1000);
    check("timeout_idle", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge sclk);
    check("timeout_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    check("timeout_err_once", n_errp - e0, 32'd1);
    check("timeout_no_strobe", (n_wr - w0) + (n_rd - r0), 32'd0);
    do_read(8'h03);

    // Backpressure on a read response
    send_byte(8'h52);
    sq.push_back('{wr: 1'b0, a: 8'h20, d: 32'd0});
    send_byte(8'h20);
    rsp_ready_i = 1'b0;
    @(posedge sclk);
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp_data", {24'd0, rsp_data_o}, {24'd0, mdl_rd(8'h20)} & 32'hFF);
      check("bp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    end
    get_rsp(4, mdl_rd(8'h20), 1'b1);

    // Asynchronous reset in the middle of a write
    w0 = n_wr;
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'hAA);
    #2;
    rstn = 1'b0;
    #1;
    check("rstmid_addr_wdata", {24'd0, reg_addr_o} | reg_wdata_o, 32'd0);
    check("rstmid_outs", {26'd0, reg_wr_o, reg_rd_o, rsp_valid_o, busy_o, err_o, 1'b0}, 32'd0);
    check("rstmid_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    repeat (3) @(negedge sclk);
    rstn = 1'b1;
    repeat (2) @(negedge sclk);
    check("rstmid_no_wr", n_wr - w0, 32'd0);
    do_write(8'h04, 32'hDEAD_BEEF);
    do_read(8'h04);

    // Randomized command mix
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 7);
      a = 8'($urandom);
      d = $urandom;
      if (k == 0) begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        do_bad(b);
      end else if (k <= 4) begin
        do_write(a, d);
      end else begin
        do_read(a);
      end
      if (($urandom_range(0, 3)) == 0) repeat ($urandom_range(1, 5)) @(negedge sclk);
    end

    wr_total = n_wr;
    repeat (3) @(negedge sclk);
    check("strobes_drained", sq.size(), 32'd0);
    check("no_late_strobes", n_wr - wr_total, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
